// File: rtl/i2c_eeprom_pkg.sv
// i2c_eeprom_pkg: state encoding, widths and EEPROM constants shared by the controller.
package i2c_eeprom_pkg;
  localparam int BYTE_W = 8;
  localparam int ADDR_W = 16;
  localparam int DEV_W = 3;
  localparam int CNT_W = 9;
  localparam int TMR_W = 16;
  localparam logic [3:0] EEPROM_CTL_NIBBLE = 4'b1010;
  localparam logic [5:0] S_IDLE = 6'b000001;
  localparam logic [5:0] S_LAUNCH = 6'b000010;
  localparam logic [5:0] S_XFER = 6'b000100;
  localparam logic [5:0] S_TAIL = 6'b001000;
  localparam logic [5:0] S_DONE = 6'b010000;
  localparam logic [5:0] S_ERR = 6'b100000;
  typedef enum logic [5:0] {
    IDLE = S_IDLE, LAUNCH = S_LAUNCH, XFER = S_XFER, TAIL = S_TAIL, DONE = S_DONE, ERR = S_ERR
  } state_t;
  function automatic logic [7:0] ctl_byte(input logic [DEV_W-1:0] dev, input logic rd);
    return {EEPROM_CTL_NIBBLE, dev, rd};
  endfunction
endpackage

// File: rtl/i2c_eeprom_ctrl_sync_fifo.sv
// sync_fifo: byte FIFO with occupancy level; a push into a full FIFO succeeds only alongside a pop.
module sync_fifo import i2c_eeprom_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push,
  input  logic [BYTE_W-1:0]         din,
  input  logic                      pop,
  output logic [BYTE_W-1:0]         dout,
  output logic [$clog2(DEPTH):0]    level
);
  localparam int AW = $clog2(DEPTH);
  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && level != '0;
  assign do_push = push && (level != (AW+1)'(DEPTH) || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/i2c_eeprom_ctrl.sv
// i2c_eeprom_ctrl: 24-series EEPROM command sequencer in front of a byte-level I2C master.
// Define I2C_EEPROM_PAGE_CHECK_EN to reject writes that would cross a PAGE_SIZE page.
module i2c_eeprom_ctrl import i2c_eeprom_pkg::*; #(
  parameter int FIFO_DEPTH = 16,
  parameter int EN_CYCLES = 4,
  parameter int DONE_WAIT = 12,
  parameter int TIMEOUT = 1024
`ifdef I2C_EEPROM_PAGE_CHECK_EN
  , parameter int PAGE_SIZE = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd,
  input  logic [DEV_W-1:0]  cmd_dev,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [BYTE_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              done,
  output logic              err,
  output logic              rx_ovf,
  output logic              m_en,
  output logic              m_read_mode,
  output logic [DEV_W-1:0]  m_dev_addr,
  output logic [ADDR_W-1:0] m_dat_addr,
  output logic [7:0]        m_tx_len,
  output logic [7:0]        m_rx_len,
  output logic [BYTE_W-1:0] m_tx_byte,
  input  logic [BYTE_W-1:0] m_rx_byte,
  input  logic              m_tx_ready,
  input  logic              m_rx_ready
);
  localparam int FW = $clog2(FIFO_DEPTH);
  state_t state, state_n;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic [CNT_W-1:0] bcnt, bcnt_n;
  logic [FW:0] tx_level, rx_level;
  logic [BYTE_W-1:0] tx_head, rx_head;
  logic len_bad, page_bad, level_ok, accept, progress, timeout;
  logic tx_full, rx_full, tx_push, tx_pop, rx_push, rx_pop, rx_drop;
`ifdef I2C_EEPROM_PAGE_CHECK_EN
  logic [ADDR_W:0] pg_sum;
  assign pg_sum = (ADDR_W+1)'(cmd_addr % ADDR_W'(PAGE_SIZE)) + (ADDR_W+1)'(cmd_len);
  assign page_bad = !cmd_rd && pg_sum >= (ADDR_W+1)'(PAGE_SIZE);
`else
  assign page_bad = 1'b0;
`endif
  assign len_bad = !cmd_rd && CNT_W'(cmd_len) >= CNT_W'(FIFO_DEPTH);
  assign level_ok = CNT_W'(tx_level) >= CNT_W'(cmd_len) + CNT_W'(1);
  assign cmd_ready = state == IDLE && (!cmd_valid || cmd_rd || len_bad || page_bad || level_ok);
  assign accept = cmd_valid && cmd_ready;
  assign progress = state == XFER && (m_read_mode ? m_rx_ready : m_tx_ready);
  assign timeout = state == XFER && !progress && tmr == '0;
  assign tx_full = tx_level == (FW+1)'(FIFO_DEPTH);
  assign rx_full = rx_level == (FW+1)'(FIFO_DEPTH);
  assign wr_ready = !tx_full;
  assign tx_push = wr_valid && !tx_full;
  assign tx_pop = state == XFER && !m_read_mode && m_tx_ready;
  assign rx_push = state == XFER && m_read_mode && m_rx_ready;
  assign rx_pop = rd_ready && rd_valid;
  assign rx_drop = rx_push && rx_full && !rx_pop;
  assign rd_valid = rx_level != '0;
  assign rd_data = rd_valid ? rx_head : '0;
  assign m_tx_byte = state == XFER ? tx_head : '0;
  assign m_en = state == LAUNCH;
  assign done = state == DONE || state == ERR;
  assign err = state == ERR;
  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .flush(timeout && !m_read_mode), .push(tx_push), .din(wr_data),
    .pop(tx_pop), .dout(tx_head), .level(tx_level)
  );
  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .flush(1'b0), .push(rx_push), .din(m_rx_byte),
    .pop(rx_pop), .dout(rx_head), .level(rx_level)
  );
  always_comb begin
    state_n = state;
    tmr_n = tmr;
    bcnt_n = bcnt;
    case (state)
      IDLE: if (accept) begin
        state_n = (len_bad || page_bad) ? ERR : LAUNCH;
        tmr_n = TMR_W'(EN_CYCLES - 1);
        bcnt_n = CNT_W'(cmd_len) + CNT_W'(1);
      end
      LAUNCH: begin
        state_n = tmr == '0 ? XFER : LAUNCH;
        tmr_n = tmr == '0 ? TMR_W'(TIMEOUT - 1) : tmr - TMR_W'(1);
      end
      XFER: if (progress) begin
        state_n = bcnt == CNT_W'(1) ? TAIL : XFER;
        tmr_n = bcnt == CNT_W'(1) ? TMR_W'(DONE_WAIT - 1) : TMR_W'(TIMEOUT - 1);
        bcnt_n = bcnt - CNT_W'(1);
      end else begin
        state_n = timeout ? ERR : XFER;
        tmr_n = tmr - TMR_W'(1);
      end
      TAIL: begin
        state_n = tmr == '0 ? DONE : TAIL;
        tmr_n = tmr - TMR_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tmr <= '0;
      bcnt <= '0;
    end else begin
      state <= state_n;
      tmr <= tmr_n;
      bcnt <= bcnt_n;
    end
  always_ff @(posedge clk)
    if (rst) begin
      m_read_mode <= 1'b0;
      m_dev_addr <= '0;
      m_dat_addr <= '0;
      m_tx_len <= '0;
      m_rx_len <= '0;
      rx_ovf <= 1'b0;
    end else if (accept) begin
      m_read_mode <= cmd_rd;
      m_dev_addr <= cmd_dev;
      m_dat_addr <= cmd_addr;
      m_tx_len <= cmd_rd ? '0 : cmd_len;
      m_rx_len <= cmd_rd ? cmd_len : '0;
      rx_ovf <= 1'b0;
    end else if (rx_drop) rx_ovf <= 1'b1;
endmodule
